// File: rtl/approx_mac_pkg.sv
// Shared types, default sizes and saturating arithmetic for the approximate MAC sequencer.
package approx_mac_pkg;

  localparam int DEF_N       = 16;
  localparam int DEF_ACC_W   = 40;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Unsigned add that clamps at 2^width-1 instead of wrapping (width <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [63:0] max_val;
    sum = {1'b0, a} + {1'b0, b};
    if (width >= 64) max_val = '1;
    else             max_val = (64'd1 << width) - 64'd1;
    if (sum > {1'b0, max_val}) sat_add = max_val;
    else                       sat_add = sum[63:0];
  endfunction

endpackage

// File: rtl/sat_accumulator.sv
// Saturating sum-of-products and pair counter with frame clear.
module sat_accumulator
  import approx_mac_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [N-1:0]     addend,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count
);

  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] count_reg;

  // Clear wins over enable; both registers clamp at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_reg   <= '0;
      count_reg <= '0;
    end else if (en) begin
      acc_reg   <= ACC_W'(sat_add(64'(acc_reg), 64'(addend), ACC_W));
      count_reg <= CNT_W'(sat_add(64'(count_reg), 64'd1, CNT_W));
    end
  end

  assign acc   = acc_reg;
  assign count = count_reg;

endmodule

// File: rtl/approx_mac_sequencer.sv
// Feeds operand pairs to the approximate multiplier, accumulates the products
// per frame and reports sum/count/error; a watchdog aborts hung multiplies.
module approx_mac_sequencer
  import approx_mac_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic             mul_reset,
  output logic [N-1:0]     mul_inp1,
  output logic [N-1:0]     mul_inp2,
  input  logic             mul_done,
  input  logic [N-1:0]     mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  // Watchdog only needs to reach TIMEOUT-1.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t          state_reg;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic            last_reg;
  logic            err_reg;
  logic [WD_W-1:0] wd_reg;

  logic accept;
  logic done_hit;
  logic timeout_hit;
  logic frame_clear;

  // Handshake and completion decode; done beats a simultaneous timeout.
  always_comb begin
    in_ready    = (state_reg == IDLE) && !rst;
    accept      = in_valid && in_ready;
    done_hit    = (state_reg == WAIT) && mul_done;
    timeout_hit = (state_reg == WAIT) && !mul_done && (wd_reg == WD_W'(TIMEOUT - 1));
    frame_clear = (state_reg == OUT) && out_ready;
  end

  // Control outputs are decoded straight from the state register.
  always_comb begin
    mul_start = (state_reg == START);
    mul_reset = rst || timeout_hit;
    out_valid = (state_reg == OUT);
    out_err   = err_reg;
    mul_inp1  = a_reg;
    mul_inp2  = b_reg;
  end

  // Sequencer FSM with operand capture, watchdog and frame error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
      wd_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            last_reg  <= in_last;
            state_reg <= START;
          end
        end
        START: begin
          // mul_done may still be high from the previous op; it is ignored here.
          wd_reg    <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (done_hit || timeout_hit) begin
            if (timeout_hit) err_reg <= 1'b1;
            state_reg <= last_reg ? OUT : IDLE;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            err_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  sat_accumulator #(
    .N     (N),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (frame_clear),
    .en     (done_hit),
    .addend (mul_result),
    .acc    (out_sum),
    .count  (out_count)
  );

endmodule
